// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer. Serial beats are collected into shadow registers and
// copied to the four lane outputs together, so a partial frame never reaches them.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             S0,
  output logic             S1,
  output logic             frame_valid,
  output logic             frame_err
);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       slot_q, slot_d;
  logic [WIDTH-1:0] shadow0_q, shadow0_d, shadow1_q, shadow1_d, shadow2_q, shadow2_d;
  logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
  logic             fv_q, fv_d, fe_q, fe_d;

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    shadow0_d = shadow0_q;
    shadow1_d = shadow1_q;
    shadow2_d = shadow2_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    out2_d    = out2_q;
    out3_d    = out3_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;
    if (in_valid) begin
      if (sync) begin
        // A sync always starts a fresh frame; mid-frame it also flags the lost partial frame.
        fe_d      = (state_q == COLLECT) && (slot_q != 2'd0);
        shadow0_d = in;
        slot_d    = 2'd1;
        state_d   = COLLECT;
      end else if (state_q == COLLECT) begin
        case (slot_q)
          2'd0: begin
            fe_d    = 1'b1;
            state_d = IDLE;
          end
          2'd1: begin
            shadow1_d = in;
            slot_d    = 2'd2;
          end
          2'd2: begin
            shadow2_d = in;
            slot_d    = 2'd3;
          end
          default: begin
            out0_d = shadow0_q;
            out1_d = shadow1_q;
            out2_d = shadow2_q;
            out3_d = in;
            fv_d   = 1'b1;
            slot_d = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      slot_q    <= 2'd0;
      shadow0_q <= '0;
      shadow1_q <= '0;
      shadow2_q <= '0;
      out0_q    <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      out3_q    <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      shadow2_q <= shadow2_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      out2_q    <= out2_d;
      out3_q    <= out3_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
    end
  end

  assign out0        = out0_q;
  assign out1        = out1_q;
  assign out2        = out2_q;
  assign out3        = out3_q;
  assign S0          = slot_q[0];
  assign S1          = slot_q[1];
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;

endmodule
